// File: rtl/rs_stream_encoder.sv
// Streaming systematic Reed-Solomon encoder with valid/ready flow control and a packed codeword view.
// Optional error injection on the emitted codeword is enabled by defining RS_ENC_ERR_INJECT_EN.
module rs_stream_encoder #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N = 7,
  parameter int K = 5,
  parameter logic [SYMBOL_WIDTH:0] PRIM_POLY = 4'b1011,
  parameter logic [(N-K)*SYMBOL_WIDTH-1:0] GEN_COEFFS = 6'b011_110
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SYMBOL_WIDTH-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [SYMBOL_WIDTH-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_first,
  output logic                      out_last,
`ifdef RS_ENC_ERR_INJECT_EN
  input  logic                      inj_en,
  input  logic [$clog2(N)-1:0]      inj_pos,
  input  logic [SYMBOL_WIDTH-1:0]   inj_mask,
`endif
  output logic [N*SYMBOL_WIDTH-1:0] cw_data,
  output logic                      cw_valid
);

  localparam int W = SYMBOL_WIDTH;
  localparam int P = N - K;
  localparam int CNT_W = $clog2(N);

  typedef logic [W-1:0] sym_t;
  typedef enum logic {ST_MSG, ST_PAR} state_t;

  // Symbols are bit-reversed (MSB = x^0), so reverse into standard order, multiply, reverse back.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t as_std;
    sym_t bs_std;
    sym_t acc;
    sym_t res;
    logic [W:0] tmp;
    for (int i = 0; i < W; i++) begin
      as_std[i] = a[W-1-i];
      bs_std[i] = b[W-1-i];
    end
    acc = '0;
    for (int i = W - 1; i >= 0; i--) begin
      tmp = {acc, 1'b0};
      if (tmp[W]) tmp = tmp ^ PRIM_POLY;
      acc = tmp[W-1:0];
      if (bs_std[i]) acc = acc ^ as_std;
    end
    for (int i = 0; i < W; i++) res[i] = acc[W-1-i];
    return res;
  endfunction

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  sym_t               lfsr_reg [P];
  sym_t               lfsr_next [P];
  sym_t               lfsr_upd [P];
  sym_t               lfsr_sh [P];
  sym_t               shadow_reg [N];
  logic [N*W-1:0]     shadow_flat;
  sym_t               out_data_reg, out_data_next;
  logic               out_valid_reg, out_valid_next;
  logic               out_first_reg, out_first_next;
  logic               out_last_reg, out_last_next;
  logic [N*W-1:0]     cw_data_reg;
  logic               cw_valid_reg;

  logic               out_free;
  logic               accept;
  logic               out_hs;
  sym_t               fb;
  sym_t               load_sym;
  sym_t               inj_xor;
  logic               shadow_we;
  sym_t               shadow_wdata;

  assign out_free = !out_valid_reg || out_ready;
  assign in_ready = (state_reg == ST_MSG) && out_free;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_reg && out_ready;
  assign fb       = in_data ^ lfsr_reg[P-1];

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_lfsr
      if (gi == 0) begin : g_low
        assign lfsr_upd[gi] = gf_mul(fb, GEN_COEFFS[gi*W +: W]);
        assign lfsr_sh[gi]  = '0;
      end else begin : g_high
        assign lfsr_upd[gi] = lfsr_reg[gi-1] ^ gf_mul(fb, GEN_COEFFS[gi*W +: W]);
        assign lfsr_sh[gi]  = lfsr_reg[gi-1];
      end
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_flat
      assign shadow_flat[(N-1-gi)*W +: W] = shadow_reg[gi];
    end
  endgenerate

`ifdef RS_ENC_ERR_INJECT_EN
  logic             inj_en_reg;
  logic [CNT_W-1:0] inj_pos_reg;
  sym_t             inj_mask_reg;
  logic             first_hs;
  logic             inj_en_eff;
  logic [CNT_W-1:0] inj_pos_eff;
  sym_t             inj_mask_eff;

  // Settings captured at the symbol-0 handshake also apply to the symbol loaded on that same edge.
  assign first_hs     = out_hs && out_first_reg;
  assign inj_en_eff   = first_hs ? inj_en   : inj_en_reg;
  assign inj_pos_eff  = first_hs ? inj_pos  : inj_pos_reg;
  assign inj_mask_eff = first_hs ? inj_mask : inj_mask_reg;
  assign inj_xor = (inj_en_eff && inj_pos_eff == cnt_reg && cnt_reg != '0) ? inj_mask_eff : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      inj_en_reg   <= 1'b0;
      inj_pos_reg  <= '0;
      inj_mask_reg <= '0;
    end else if (first_hs) begin
      inj_en_reg   <= inj_en;
      inj_pos_reg  <= inj_pos;
      inj_mask_reg <= inj_mask;
    end
  end
`else
  assign inj_xor = '0;
`endif

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lfsr_next      = lfsr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg && !out_ready;
    out_first_next = out_first_reg;
    out_last_next  = out_last_reg;
    load_sym       = '0;
    shadow_we      = 1'b0;
    shadow_wdata   = '0;
    case (state_reg)
      ST_MSG: begin
        if (accept) begin
          load_sym       = in_data;
          lfsr_next      = lfsr_upd;
          shadow_we      = 1'b1;
          out_valid_next = 1'b1;
          out_first_next = (cnt_reg == '0);
          out_last_next  = 1'b0;
          cnt_next       = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(K - 1)) state_next = ST_PAR;
        end
      end
      ST_PAR: begin
        if (out_free) begin
          load_sym       = lfsr_reg[P-1];
          lfsr_next      = lfsr_sh;
          shadow_we      = 1'b1;
          out_valid_next = 1'b1;
          out_first_next = 1'b0;
          out_last_next  = (cnt_reg == CNT_W'(N - 1));
          cnt_next       = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(N - 1)) begin
            state_next = ST_MSG;
            cnt_next   = '0;
            for (int j = 0; j < P; j++) lfsr_next[j] = '0;
          end
        end
      end
      default: state_next = ST_MSG;
    endcase
    if (shadow_we) begin
      shadow_wdata  = load_sym ^ inj_xor;
      out_data_next = load_sym ^ inj_xor;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_MSG;
      cnt_reg       <= '0;
      for (int j = 0; j < P; j++) lfsr_reg[j] <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      cw_data_reg   <= '0;
      cw_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      lfsr_reg      <= lfsr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_first_reg <= out_first_next;
      out_last_reg  <= out_last_next;
      // The next frame may write shadow[0] on this same edge; cw_data takes the old contents.
      cw_valid_reg  <= out_hs && out_last_reg;
      if (out_hs && out_last_reg) cw_data_reg <= shadow_flat;
    end
  end

  always_ff @(posedge clk) begin
    if (shadow_we) shadow_reg[cnt_reg] <= shadow_wdata;
`ifdef RS_ENC_ERR_INJECT_EN
    if (!reset && first_hs && inj_en && inj_pos == '0) shadow_reg[0] <= shadow_reg[0] ^ inj_mask;
`endif
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_first = out_first_reg;
  assign out_last  = out_last_reg;
  assign cw_data   = cw_data_reg;
  assign cw_valid  = cw_valid_reg;

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Scoreboard bench for rs_stream_encoder: driver queues expected symbols and codewords, a monitor checks them.
module tb_rs_stream_encoder;
  localparam int W = 3;
  localparam int N = 7;
  localparam int K = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic out_first;
  logic out_last;
  logic [N*W-1:0] cw_data;
  logic cw_valid;
`ifdef RS_ENC_ERR_INJECT_EN
  logic inj_en = 1'b0;
  logic [$clog2(N)-1:0] inj_pos = '0;
  logic [W-1:0] inj_mask = '0;
`endif

  rs_stream_encoder dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last),
`ifdef RS_ENC_ERR_INJECT_EN
    .inj_en(inj_en), .inj_pos(inj_pos), .inj_mask(inj_mask),
`endif
    .cw_data(cw_data), .cw_valid(cw_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic f;
    logic l;
  } exp_t;

  exp_t exp_q[$];
  logic [N*W-1:0] cw_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Output-side backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: symbol stream, hold-while-stalled, in_ready during parity, codeword pulses.
  initial begin
    int hs_cnt;
    bit stall;
    logic [W-1:0] held;
    exp_t e;
    logic [N*W-1:0] ecw;
    hs_cnt = 0;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hs_cnt = 0;
        stall = 1'b0;
      end else begin
        if (stall) begin
          n_cmp++;
          if (!out_valid || out_data !== held) begin
            n_fail++;
            $display("FAIL hold: out_valid=%b out_data=%b, required 1/%b", out_valid, out_data, held);
          end
        end
        if (out_valid) begin
          if (hs_cnt >= K - 1 && hs_cnt <= N - 2) check("in_ready_par", 32'(in_ready), 32'd0);
          if (out_ready) begin
            stall = 1'b0;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_sym: got %b, required no output", out_data);
            end else begin
              e = exp_q.pop_front();
              $display("sym idx=%0d data=%b first=%b last=%b", hs_cnt, out_data, out_first, out_last);
              check("out_sym", 32'({out_data, out_first, out_last}), 32'(e));
            end
            hs_cnt = (hs_cnt == N - 1) ? 0 : hs_cnt + 1;
          end else begin
            stall = 1'b1;
            held = out_data;
          end
        end else begin
          stall = 1'b0;
        end
        if (cw_valid) begin
          if (cw_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_cw: got %h, required no cw_valid", cw_data);
          end else begin
            ecw = cw_q.pop_front();
            $display("cw data=%h", cw_data);
            check("cw_data", 32'(cw_data), 32'(ecw));
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [K*W-1:0] msg, input logic [N*W-1:0] cw, input int nsym);
    exp_t e;
    bit acc;
    int tmo;
    for (int i = 0; i < N; i++) begin
      e.d = cw[(N-1-i)*W +: W];
      e.f = (i == 0);
      e.l = (i == N - 1);
      exp_q.push_back(e);
    end
    if (nsym == K) cw_q.push_back(cw);
    for (int i = 0; i < nsym; i++) begin
      in_data = msg[(K-1-i)*W +: W];
      in_valid = 1'b1;
      tmo = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        tmo++;
      end while (!acc && tmo < 200);
      if (!acc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: symbol %0d not accepted, required acceptance", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int tmo;
    tmo = 0;
    while ((exp_q.size() != 0 || cw_q.size() != 0) && tmo < 1000) begin
      @(posedge clk);
      tmo++;
    end
    if (tmo >= 1000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d symbols %0d codewords pending, required 0", exp_q.size(), cw_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_cw_valid", 32'(cw_valid), 32'd0);
    check("rst_cw_data", 32'(cw_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back frames without backpressure.
    send_frame(15'b000_000_000_000_000, 21'h000000, K);
    send_frame(15'b000_000_000_000_100, 21'h00011E, K);
    send_frame(15'b100_000_000_000_000, 21'h10001A, K);
    send_frame(15'b000_000_000_100_000, 21'h000824, K);
    drain();

    rand_ready = 1'b1;
    send_frame(15'b100_000_000_000_000, 21'h10001A, K);
    send_frame(15'b000_000_000_000_100, 21'h00011E, K);
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Abort a frame after three symbols.
    send_frame(15'b100_000_000_000_000, 21'h10001A, 3);
    reset = 1'b1;
    exp_q.delete();
    cw_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send_frame(15'b000_000_000_000_100, 21'h00011E, K);
    drain();

`ifdef RS_ENC_ERR_INJECT_EN
    inj_en = 1'b1;
    inj_pos = 3'd6;
    inj_mask = 3'b001;
    send_frame(15'b000_000_000_000_100, 21'h00011F, K);
    drain();
    inj_en = 1'b0;
`endif

    check("cw_pending", 32'(cw_q.size()), 32'd0);
    check("sym_pending", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
